// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared constants, state encoding and helpers for the Ascon hash core
package ascon_pkg;

  localparam logic [63:0] IV_HASH  = 64'h00400c0000000100;
  localparam logic [63:0] IV_HASHA = 64'h00400c0400000100;
  localparam logic [63:0] IV_XOF   = 64'h00400c0000000000;

  localparam int MODE_HASH  = 0;
  localparam int MODE_HASHA = 1;
  localparam int MODE_XOF   = 2;

  localparam int P_A = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ABSORB,
    ST_PERM_B,
    ST_PERM_PAD,
    ST_PERM_A,
    ST_SQUEEZE,
    ST_PERM_SQ
  } state_t;

  // Round constant for absolute round index 0..11 (p^b starts at 12-b).
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'hf0;
      4'd1:    return 8'he1;
      4'd2:    return 8'hd2;
      4'd3:    return 8'hc3;
      4'd4:    return 8'hb4;
      4'd5:    return 8'ha5;
      4'd6:    return 8'h96;
      4'd7:    return 8'h87;
      4'd8:    return 8'h78;
      4'd9:    return 8'h69;
      4'd10:   return 8'h5a;
      4'd11:   return 8'h4b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon permutation round
module ascon_round
  import ascon_pkg::*;
(
  input  logic [319:0] i_state,
  input  logic [3:0]   i_round,
  output logic [319:0] o_state
);

  logic [63:0] w_x0, w_x1, w_x2, w_x3, w_x4;
  logic [63:0] w_a0, w_a2, w_a4;
  logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;
  logic [63:0] w_b0, w_b1, w_b2, w_b3, w_b4;
  logic [63:0] w_s0, w_s1, w_s2, w_s3, w_s4;

  assign {w_x0, w_x1, w_x2, w_x3, w_x4} = i_state;

  // Constant addition folded into the S-box input mixing (x2 ^= c, then x2 ^= x1).
  assign w_a0 = w_x0 ^ w_x4;
  assign w_a2 = w_x2 ^ {56'd0, round_const(i_round)} ^ w_x1;
  assign w_a4 = w_x4 ^ w_x3;

  // Chi-like core of the bitsliced 5-bit S-box.
  assign w_t0 = ~w_a0 & w_x1;
  assign w_t1 = ~w_x1 & w_a2;
  assign w_t2 = ~w_a2 & w_x3;
  assign w_t3 = ~w_x3 & w_a4;
  assign w_t4 = ~w_a4 & w_a0;

  assign w_b0 = w_a0 ^ w_t1;
  assign w_b1 = w_x1 ^ w_t2;
  assign w_b2 = w_a2 ^ w_t3;
  assign w_b3 = w_x3 ^ w_t4;
  assign w_b4 = w_a4 ^ w_t0;

  assign w_s0 = w_b0 ^ w_b4;
  assign w_s1 = w_b1 ^ w_b0;
  assign w_s2 = ~w_b2;
  assign w_s3 = w_b3 ^ w_b2;
  assign w_s4 = w_b4;

  // Per-word linear diffusion layer.
  assign o_state = {
    w_s0 ^ ror64(w_s0, 19) ^ ror64(w_s0, 28),
    w_s1 ^ ror64(w_s1, 61) ^ ror64(w_s1, 39),
    w_s2 ^ ror64(w_s2, 1)  ^ ror64(w_s2, 6),
    w_s3 ^ ror64(w_s3, 10) ^ ror64(w_s3, 17),
    w_s4 ^ ror64(w_s4, 7)  ^ ror64(w_s4, 41)
  };

endmodule

// File: rtl/ascon_hash_core.sv
// rtl/ascon_hash_core.sv - Ascon-Hash/Hasha/Xof engine with stream absorb and squeeze
module ascon_hash_core
  import ascon_pkg::*;
#(
  parameter int BW     = 64,
  parameter int UNROLL = 1,
  parameter int MODE   = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [7:0]    xof_words,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_data,
  input  logic [3:0]    in_bytes,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  // UNROLL must divide the round count of the selected variant (8 for Hasha).
  localparam int P_B = (MODE == MODE_HASH || MODE == MODE_XOF) ? P_A : 8;
  localparam logic [63:0] IV = (MODE == MODE_HASHA) ? IV_HASHA :
                               (MODE == MODE_XOF)   ? IV_XOF   : IV_HASH;

  state_t       r_state, w_next;
  logic [319:0] r_s;
  logic [3:0]   r_round;
  logic [8:0]   r_remaining;

  logic [319:0] w_chain [UNROLL+1];
  logic [4:0]   w_round_sum;
  logic         w_perm_last;
  logic         w_is_perm;
  logic         w_full;
  logic [63:0]  w_mask, w_pad, w_absorb;
  logic [8:0]   w_words;
  logic [3:0]   w_round_start;

  assign w_chain[0] = r_s;
  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    ascon_round u_round (
      .i_state (w_chain[j]),
      .i_round (r_round + 4'(j)),
      .o_state (w_chain[j+1])
    );
  end

  assign w_round_sum = 5'(r_round) + 5'(UNROLL);
  assign w_perm_last = (w_round_sum == 5'd12);
  assign w_is_perm   = (r_state == ST_INIT) || (r_state == ST_PERM_B) || (r_state == ST_PERM_PAD) ||
                       (r_state == ST_PERM_A) || (r_state == ST_PERM_SQ);

  // A non-last block is always treated as full, whatever in_bytes says.
  assign w_full   = !in_last || (in_bytes >= 4'd8);
  assign w_mask   = ~(64'hffff_ffff_ffff_ffff >> {in_bytes[2:0], 3'b000});
  assign w_pad    = 64'h8000_0000_0000_0000 >> {in_bytes[2:0], 3'b000};
  assign w_absorb = w_full ? 64'(in_data) : ((64'(in_data) & w_mask) ^ w_pad);

  assign w_words       = (MODE == MODE_XOF) ? ((xof_words == 8'd0) ? 9'd256 : {1'b0, xof_words}) : 9'd4;
  assign w_round_start = (w_next == ST_PERM_B || w_next == ST_PERM_PAD || w_next == ST_PERM_SQ) ?
                         4'(12 - P_B) : 4'(12 - P_A);

  assign out_data = out_valid ? BW'(r_s[319:256]) : '0;
  assign out_last = out_valid && (r_remaining == 9'd1);
  assign busy     = (r_state != ST_IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and stream handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE:     if (start) w_next = ST_INIT;
      ST_INIT:     if (w_perm_last) w_next = ST_ABSORB;
      ST_ABSORB: begin
        in_ready = 1'b1;
        if (in_valid) w_next = !in_last ? ST_PERM_B : (w_full ? ST_PERM_PAD : ST_PERM_A);
      end
      ST_PERM_B:   if (w_perm_last) w_next = ST_ABSORB;
      ST_PERM_PAD: if (w_perm_last) w_next = ST_PERM_A;
      ST_PERM_A:   if (w_perm_last) w_next = ST_SQUEEZE;
      ST_SQUEEZE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = (r_remaining > 9'd1) ? ST_PERM_SQ : ST_IDLE;
      end
      ST_PERM_SQ:  if (w_perm_last) w_next = ST_SQUEEZE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Sponge state, round counter and remaining digest words.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s         <= '0;
      r_round     <= '0;
      r_remaining <= '0;
    end else begin
      if (r_state != w_next) r_round <= w_round_start;
      else if (w_is_perm)    r_round <= w_round_sum[3:0];
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_s         <= {IV, 256'd0};
            r_remaining <= w_words;
          end
        end
        ST_ABSORB: begin
          if (in_valid) r_s[319:256] <= r_s[319:256] ^ w_absorb;
        end
        ST_SQUEEZE: begin
          if (out_ready && r_remaining > 9'd1) r_remaining <= r_remaining - 9'd1;
        end
        ST_PERM_PAD: begin
          r_s <= w_chain[UNROLL];
          if (w_perm_last) r_s[319:256] <= w_chain[UNROLL][319:256] ^ 64'h8000_0000_0000_0000;
        end
        default: begin
          if (w_is_perm) r_s <= w_chain[UNROLL];
        end
      endcase
    end
  end

endmodule
